// File: rtl/fsm_updown_counter.sv
// Bidirectional loadable counter over 0..MAX: wraps or saturates at the range ends,
// flags the ends combinationally and pulses wrap for one cycle after a wrap-around step.
module fsm_updown_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MAX      = (1 << WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] num,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] num_q, num_d;
    logic             wrap_q, wrap_d;
    logic             illegal;
    logic             load_over;

    // With a full-range MAX no value can exceed it, so the comparators are not built.
    generate
        if (MAX_V != '1) begin : g_partial_range
            assign illegal   = (num_q > MAX_V);
            assign load_over = (load_val > MAX_V);
        end else begin : g_full_range
            assign illegal   = 1'b0;
            assign load_over = 1'b0;
        end
    endgenerate

    always_comb begin
        num_d  = num_q;
        wrap_d = 1'b0;
        if (load) begin
            num_d = load_over ? MAX_V : load_val;
        end else if (illegal) begin
            num_d = '0;
        end else if (en) begin
            if (up) begin
                if (num_q == MAX_V) begin
                    if (SATURATE) begin
                        num_d = MAX_V;
                    end else begin
                        num_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    num_d = num_q + ONE_V;
                end
            end else begin
                if (num_q == '0) begin
                    if (SATURATE) begin
                        num_d = '0;
                    end else begin
                        num_d  = MAX_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    num_d = num_q - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            wrap_q <= wrap_d;
        end
    end

    assign num    = num_q;
    assign wrap   = wrap_q;
    assign at_max = (num_q == MAX_V);
    assign at_min = (num_q == '0);

endmodule

// File: tb/tb_fsm_updown_counter.sv
// Bench for fsm_updown_counter: three configurations (MAX=7 wrap, MAX=5 saturate,
// MAX=5 wrap) share one stimulus stream and are checked against a range-arithmetic model.
module tb_fsm_updown_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = '0;

    logic [2:0] num_o    [3];
    logic       at_max_o [3];
    logic       at_min_o [3];
    logic       wrap_o   [3];

    int tests = 0;
    int fails = 0;

    int mnum  [3] = '{0, 0, 0};
    int mwrap [3] = '{0, 0, 0};
    int maxs  [3] = '{7, 5, 5};
    int sats  [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    fsm_updown_counter #(.WIDTH(3), .MAX(7), .SATURATE(1'b0)) u_w7 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .num(num_o[0]), .at_max(at_max_o[0]), .at_min(at_min_o[0]), .wrap(wrap_o[0])
    );
    fsm_updown_counter #(.WIDTH(3), .MAX(5), .SATURATE(1'b1)) u_s5 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .num(num_o[1]), .at_max(at_max_o[1]), .at_min(at_min_o[1]), .wrap(wrap_o[1])
    );
    fsm_updown_counter #(.WIDTH(3), .MAX(5), .SATURATE(1'b0)) u_w5 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .num(num_o[2]), .at_max(at_max_o[2]), .at_min(at_min_o[2]), .wrap(wrap_o[2])
    );

    // Model: step by +/-1 in plain integers, then fold back into 0..MAX.
    function automatic void model_step();
        int t;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                mnum[i]  = 0;
                mwrap[i] = 0;
            end else if (load) begin
                mnum[i]  = (int'(load_val) > maxs[i]) ? maxs[i] : int'(load_val);
                mwrap[i] = 0;
            end else if (en) begin
                t = mnum[i] + (up ? 1 : -1);
                if (t < 0 || t > maxs[i]) begin
                    if (sats[i] != 0) begin
                        mnum[i]  = (t < 0) ? 0 : maxs[i];
                        mwrap[i] = 0;
                    end else begin
                        mnum[i]  = (t + maxs[i] + 1) % (maxs[i] + 1);
                        mwrap[i] = 1;
                    end
                end else begin
                    mnum[i]  = t;
                    mwrap[i] = 0;
                end
            end else begin
                mwrap[i] = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (num_o[i] !== 3'd0 || wrap_o[i] !== 1'b0 || at_min_o[i] !== 1'b1 || at_max_o[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset inst%0d: num=%0d wrap=%b at_min=%b at_max=%b, want 0 0 1 0",
                         i, num_o[i], wrap_o[i], at_min_o[i], at_max_o[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        int exp_num [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            tests++;
            if (num_o[0] !== 3'(exp_num[k]) || wrap_o[0] !== (k == 7) || at_max_o[0] !== (k == 6)) begin
                fails++;
                $display("FAIL wrap_up step%0d: num=%0d wrap=%b at_max=%b, want %0d %b %b",
                         k, num_o[0], wrap_o[0], at_max_o[0], exp_num[k], (k == 7), (k == 6));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        int exp_num [4] = '{1, 0, 7, 6};
        load = 1'b1; load_val = 3'd2;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if (num_o[0] !== 3'(exp_num[k]) || wrap_o[0] !== (k == 2) || at_min_o[0] !== (k == 1)) begin
                fails++;
                $display("FAIL count_down step%0d: num=%0d wrap=%b at_min=%b, want %0d %b %b",
                         k, num_o[0], wrap_o[0], at_min_o[0], exp_num[k], (k == 2), (k == 1));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_dn [6] = '{4, 3, 2, 1, 0, 0};
        load = 1'b1; load_val = 3'd4;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (num_o[1] !== 3'd5 || at_max_o[1] !== 1'b1 || wrap_o[1] !== 1'b0) begin
                fails++;
                $display("FAIL sat_up step%0d: num=%0d at_max=%b wrap=%b, want 5 1 0",
                         k, num_o[1], at_max_o[1], wrap_o[1]);
            end
        end
        up = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            tests++;
            if (num_o[1] !== 3'(exp_dn[k]) || wrap_o[1] !== 1'b0) begin
                fails++;
                $display("FAIL sat_down step%0d: num=%0d wrap=%b, want %0d 0",
                         k, num_o[1], wrap_o[1], exp_dn[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_val = 3'd7; en = 1'b1; up = 1'b1;
        step();
        tests++;
        if (num_o[0] !== 3'd7 || num_o[1] !== 3'd5 || num_o[2] !== 3'd5 || at_max_o[2] !== 1'b1) begin
            fails++;
            $display("FAIL load_clamp: nums=%0d/%0d/%0d at_max5=%b, want 7/5/5 1",
                     num_o[0], num_o[1], num_o[2], at_max_o[2]);
        end
        load_val = 3'd2;
        step();
        tests++;
        if (num_o[2] !== 3'd2 || wrap_o[2] !== 1'b0 || wrap_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL load_priority: num=%0d wrap=%b wrap7=%b, want 2 0 0",
                     num_o[2], wrap_o[2], wrap_o[0]);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_direction();
        int exp_num [4] = '{4, 3, 4, 3};
        load = 1'b1; load_val = 3'd3;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up = (k % 2 == 0);
            step();
            tests++;
            if (num_o[0] !== 3'(exp_num[k])) begin
                fails++;
                $display("FAIL direction step%0d: num=%0d, want %0d", k, num_o[0], exp_num[k]);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            up = ~up;
            step();
            tests++;
            if (num_o[0] !== 3'd3 || wrap_o[0] !== 1'b0) begin
                fails++;
                $display("FAIL hold step%0d: num=%0d wrap=%b, want 3 0", k, num_o[0], wrap_o[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp7 [4] = '{7, 0, 7, 0};
        load = 1'b1; load_val = 3'd0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up = (k % 2 == 1);
            step();
            tests++;
            if (num_o[0] !== 3'(exp7[k]) || wrap_o[0] !== 1'b1) begin
                fails++;
                $display("FAIL back_to_back step%0d: num=%0d wrap=%b, want %0d 1",
                         k, num_o[0], wrap_o[0], exp7[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 3'd5;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        tests++;
        if (num_o[0] !== 3'd6) begin
            fails++;
            $display("FAIL async_pre: num=%0d, want 6", num_o[0]);
        end
        #2 load = 1'b1; load_val = 3'd4;
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (num_o[0] !== 3'd0 || wrap_o[0] !== 1'b0 || at_min_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL async_clear: num=%0d wrap=%b at_min=%b, want 0 0 1",
                     num_o[0], wrap_o[0], at_min_o[0]);
        end
        step();
        tests++;
        if (num_o[0] !== 3'd0 || num_o[1] !== 3'd0 || num_o[2] !== 3'd0) begin
            fails++;
            $display("FAIL async_hold: nums=%0d/%0d/%0d, want 0/0/0", num_o[0], num_o[1], num_o[2]);
        end
        reset_n = 1'b1; load = 1'b0;
        step();
        tests++;
        if (num_o[0] !== 3'd1) begin
            fails++;
            $display("FAIL async_resume: num=%0d, want 1", num_o[0]);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load     = ($urandom_range(0, 7) == 0);
            load_val = 3'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            step();
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (num_o[i] !== 3'(mnum[i]) || wrap_o[i] !== 1'(mwrap[i]) ||
                    at_max_o[i] !== (mnum[i] == maxs[i]) || at_min_o[i] !== (mnum[i] == 0)) begin
                    fails++;
                    $display("FAIL random c%0d inst%0d: num=%0d wrap=%b at_max=%b at_min=%b, want %0d %0d %b %b",
                             c, i, num_o[i], wrap_o[i], at_max_o[i], at_min_o[i],
                             mnum[i], mwrap[i], (mnum[i] == maxs[i]), (mnum[i] == 0));
                end
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_count_down();
        test_saturation();
        test_load_clamp();
        test_direction();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fsm_updown_counter.md
# fsm_updown_counter

Bidirectional, loadable FSM counter. Each enabled clock it moves one state up or down the count sequence, wrapping or saturating at the ends. It can be preloaded with any value and flags the ends of the range. It is the count-down/count-up companion to the existing up-only FSM counter and serves as a general-purpose event counter and countdown timer in the design.

## Interface
- WIDTH, 3, bit width of the count state.
- MAX, 2**WIDTH-1, highest count state; legal range 1..2**WIDTH-1.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured on load.
- num  output  WIDTH  current count state (registered).
- at_max  output  1  combinational, high when num == MAX.
- at_min  output  1  combinational, high when num == 0.
- wrap  output  1  registered one-cycle pulse; high in the cycle after a wrap-around step.

## Operation
- The state register holds the count, with states 0..MAX. Next-state logic is a single combinational block. The output num is the state register itself.
- Priority each cycle: load > en > hold.
- Load: next = load_val if load_val <= MAX, else MAX (clamped). Direction and en are ignored. wrap_next = 0.
- en=1, up=1:
  - state < MAX: next = state+1.
  - state == MAX: with SATURATE=0, next = 0 and wrap_next = 1; with SATURATE=1, next = MAX and wrap_next = 0.
- en=1, up=0:
  - state > 0: next = state-1.
  - state == 0: with SATURATE=0, next = MAX and wrap_next = 1; with SATURATE=1, next = 0 and wrap_next = 0.
- en=0 and load=0: next = state, wrap_next = 0.
- Any state value above MAX (reachable only when MAX < 2**WIDTH-1, through an upset) is illegal. It forces next = 0 regardless of inputs other than load.
- Arithmetic is WIDTH bits, unsigned. Compare against MAX explicitly. Never rely on natural 2**WIDTH rollover, because MAX may be smaller.
- The direction input may change on any cycle. The step takes the up value sampled at that edge. There is no turnaround penalty.

## Timing
- Reset (reset_n low, asynchronous): num = 0, wrap = 0, at_min = 1, at_max = 0 (at_max = 1 only if MAX == 0, which is illegal). Outputs stay at these values while reset_n is low.
- Reset release: the first rising edge with reset_n high evaluates inputs normally.
- Reset asserted mid-count clears the count immediately, without waiting for a clock edge. A load pending in that cycle is discarded.
- Latency: num reflects a step or load one clock after the edge at which en or load is sampled high.
- wrap rises in the same cycle num shows the wrapped value (0 or MAX) and lasts exactly one cycle, unless the next enabled step also wraps. That can happen only for MAX=1 alternating, or for repeated wraps.
- at_max and at_min follow num combinationally, with no added latency.
- Simultaneous load and en at a range end: the load wins and wrap stays low.

## Test plan
- Reset then wrap up: WIDTH=3, MAX=7, SATURATE=0. Assert reset_n=0 → num=0, wrap=0, at_min=1. Release, then en=1, up=1 for 9 clocks → num = 1..7, 0, 1. wrap is high only in the cycle num=0 after 7.
- Count down and wrap: same config. Load 2, then en=1, up=0 for 4 clocks → num = 1, 0, 7, 6. wrap is high in the cycle num=7. at_min is high while num=0.
- Saturation: SATURATE=1, MAX=5. Load 4, then en=1, up=1 for 3 clocks → num = 5, 5, 5, with at_max=1 and wrap=0 throughout. Then up=0 for 6 clocks → num = 4..0, 0.
- Load clamp and priority: MAX=5. Assert load=1, load_val=7, en=1 → next num=5. With num=5, assert load=1, load_val=2, en=1, up=1 → num=2 and wrap=0.
- Hold and direction change: toggle up every clock with en=1, starting from 3 → num = 4, 3, 4, 3. Then en=0 for 3 clocks → num holds at 3.
- Async reset mid-count: while counting at num=6, pull reset_n low between clock edges → num=0 and wrap=0 before the next edge. Counting resumes from 0 after release.
